// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit MIPS-style pipeline: widths, special encodings,
// the fetch FSM state type and the IF/ID pipeline bundle.
package cpu_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

    localparam logic [INST_W-1:0] HALT_WORD = 16'hFFFF;
    localparam logic [INST_W-1:0] NOP_WORD  = 16'h0000;
    localparam logic [PC_W-1:0]   RESET_PC  = 8'h00;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   pc_plus1;
    } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load, hold or flush with asynchronous active-high reset.
// Flush kills valid and the instruction but keeps the pc fields for debug visibility.
module if_id_reg
    import cpu_pkg::*;
#(
    parameter logic [INST_W-1:0] FLUSH_INST = NOP_WORD
) (
    input  logic   i_clk,
    input  logic   i_rst,
    input  logic   i_load,
    input  logic   i_flush,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q.valid    <= 1'b0;
            r_q.inst     <= FLUSH_INST;
            r_q.pc       <= '0;
            r_q.pc_plus1 <= '0;
        end else if (i_flush) begin
            r_q.valid <= 1'b0;
            r_q.inst  <= FLUSH_INST;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/inst_fetch_stage.sv
// Instruction-fetch stage: PC, RUN/HALTED FSM and IF/ID capture of the async-read RAM word.
// Define FETCH_PERF_CNT_EN to add saturating fetch/stall performance counters.
module inst_fetch_stage
    import cpu_pkg::*;
#(
    parameter logic [PC_W-1:0]   P_RESET_PC  = RESET_PC,
    parameter logic [INST_W-1:0] P_HALT_WORD = HALT_WORD,
    parameter logic [INST_W-1:0] P_NOP_WORD  = NOP_WORD
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   imem_add,
    input  logic [INST_W-1:0] imem_dout,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              if_valid,
    output logic [INST_W-1:0] if_inst,
    output logic [PC_W-1:0]   if_pc,
    output logic [PC_W-1:0]   if_pc_plus1,
    output logic              halted,
`ifdef FETCH_PERF_CNT_EN
    output logic [15:0]       perf_fetch_cnt,
    output logic [15:0]       perf_stall_cnt,
`endif
    output fetch_state_t      dbg_state
);

    logic [PC_W-1:0] r_pc;
    fetch_state_t    r_state;
    logic            r_halted;

    logic            w_load;
    logic            w_flush;
    logic            w_is_halt;
    logic [PC_W-1:0] w_pc_inc;
    if_id_t          w_d;
    if_id_t          w_q;

    assign w_pc_inc  = r_pc + 1'b1;
    assign w_is_halt = (imem_dout == P_HALT_WORD);

    // Redirect always flushes; when halted, an unstalled cycle drains the held HALT.
    always_comb begin
        w_load  = 1'b0;
        w_flush = 1'b0;
        case (r_state)
            RUN: begin
                if (redirect_valid)  w_flush = 1'b1;
                else if (!stall)     w_load  = 1'b1;
            end
            HALTED: begin
                if (redirect_valid || !stall) w_flush = 1'b1;
            end
            default: w_flush = 1'b1;
        endcase
    end

    always_comb begin
        w_d.valid    = 1'b1;
        w_d.inst     = imem_dout;
        w_d.pc       = r_pc;
        w_d.pc_plus1 = w_pc_inc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= P_RESET_PC;
            r_state  <= RUN;
            r_halted <= 1'b0;
        end else begin
            case (r_state)
                RUN: begin
                    if (redirect_valid) begin
                        r_pc <= redirect_pc;
                    end else if (!stall) begin
                        if (w_is_halt) begin
                            r_state  <= HALTED;
                            r_halted <= 1'b1;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                HALTED: begin
                    if (redirect_valid) begin
                        r_pc     <= redirect_pc;
                        r_state  <= RUN;
                        r_halted <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= RUN;
                    r_halted <= 1'b0;
                end
            endcase
        end
    end

    if_id_reg #(
        .FLUSH_INST (P_NOP_WORD)
    ) u_if_id (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_load  (w_load),
        .i_flush (w_flush),
        .i_d     (w_d),
        .o_q     (w_q)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] r_fetch_cnt;
    logic [15:0] r_stall_cnt;
    logic        w_stall_evt;

    assign w_stall_evt = (r_state == RUN) && stall && !redirect_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_load && (r_fetch_cnt != 16'hFFFF))      r_fetch_cnt <= r_fetch_cnt + 16'd1;
            if (w_stall_evt && (r_stall_cnt != 16'hFFFF)) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign perf_fetch_cnt = r_fetch_cnt;
    assign perf_stall_cnt = r_stall_cnt;
`endif

    assign imem_add    = r_pc;
    assign if_valid    = w_q.valid;
    assign if_inst     = w_q.inst;
    assign if_pc       = w_q.pc;
    assign if_pc_plus1 = w_q.pc_plus1;
    assign halted      = r_halted;
    assign dbg_state   = r_state;

endmodule

// File: doc/inst_fetch_stage.md
Name: inst_fetch_stage

Overview:
- Instruction-fetch stage of the 16-bit MIPS-style pipeline.
- Owns the program counter, drives the address of the single-port instruction RAM, and captures its asynchronously read word into the IF/ID pipeline register.
- Handles decode-stage stalls, branch/jump redirects (with flush), and a HALT instruction.
- Sits between the instruction RAM (8-bit address, 16-bit data, combinational read) and the decode stage.

Parameters:
- PC_W, 8, program-counter and instruction-address width
- INST_W, 16, instruction width
- RESET_PC, 0, PC value loaded on reset
- HALT_WORD, 16'hFFFF, instruction encoding that stops fetch
- NOP_WORD, 16'h0000, encoding placed in the IF/ID register on flush/reset

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- imem_add  out  PC_W  instruction RAM address; combinational copy of PC
- imem_dout  in  INST_W  instruction RAM read data, valid in the same cycle
- stall  in  1  decode cannot accept; hold PC and IF/ID
- redirect_valid  in  1  branch/jump taken this cycle
- redirect_pc  in  PC_W  target address
- if_valid  out  1  IF/ID register holds a live instruction
- if_inst  out  INST_W  IF/ID instruction
- if_pc  out  PC_W  address of if_inst
- if_pc_plus1  out  PC_W  if_pc+1, modulo 2^PC_W
- halted  out  1  fetch stopped on HALT_WORD

Behaviour:
- Interface: one clock (clk); rst is asynchronous and active-high.
- Reset values, applied immediately on rst and independent of clk:
  - pc=RESET_PC, state=RUN
  - if_valid=0, if_inst=NOP_WORD, if_pc=0, if_pc_plus1=0
  - halted=0
- Reset mid-operation discards any in-flight instruction. First fetch from RESET_PC occurs on the first rising edge after rst deasserts.
- imem_add = pc at all times (combinational). Zero-cycle RAM latency; a word is in IF/ID one cycle after its address is presented.
- FSM has two states, RUN and HALTED. Priority each edge: redirect_valid > stall > normal.
- RUN, redirect_valid=1:
  - pc<=redirect_pc; if_valid<=0; if_inst<=NOP_WORD (flush).
  - Stall is ignored this cycle.
- RUN, stall=1 and no redirect: pc and all if_* hold their values.
- RUN, normal:
  - if_inst<=imem_dout, if_pc<=pc, if_pc_plus1<=pc+1, if_valid<=1.
  - pc<=pc+1, wrapping 2^PC_W-1 to 0.
- RUN, normal with imem_dout==HALT_WORD:
  - HALT is latched into IF/ID with if_valid=1 so decode sees it.
  - pc holds at the HALT address; state->HALTED; halted<=1.
- HALTED:
  - No fetch; pc holds.
  - If stall=0: if_valid<=0 and if_inst<=NOP_WORD. If stall=1: IF/ID holds until consumed.
  - redirect_valid=1: pc<=redirect_pc, IF/ID flushed, state->RUN, halted<=0.
- Simultaneous redirect and HALT fetch: redirect wins; the HALT is not latched and state stays RUN.
- Writes to the instruction RAM are outside this block; no fetch/write hazard handling.

Optional Feature:
- Macro FETCH_PERF_CNT_EN.
- When defined, adds two output ports:
  - perf_fetch_cnt[15:0]: increments on each normal IF/ID load.
  - perf_stall_cnt[15:0]: increments on each RUN cycle with stall=1 and no redirect.
- Both counters saturate at 16'hFFFF and reset to 0 on rst.
- When not defined, the ports and counters are absent and behaviour is otherwise identical.

Decomposition:
- Shared package (cpu_pkg):
  - PC_W, INST_W, HALT_WORD, NOP_WORD constants
  - fetch state enum {RUN, HALTED}
  - IF/ID bundle typedef {valid, inst, pc, pc_plus1}
- One natural sub-module: if_id_reg (load/hold/flush pipeline register with async reset), reused by later pipeline stages.
- PC logic and FSM stay in the top module.

Test Plan:
- Reset release, RAM[0..3]=16'h1111,2222,3333,4444, no stall -> imem_add 0,1,2,3 on successive cycles; if_inst 1111 with if_pc=0, if_pc_plus1=1 one cycle after each address.
- Stall high for 3 cycles while if_inst=2222 -> pc stays 2, IF/ID holds 2222/pc 1 for 3 cycles; fetch resumes at 2 (3333) after release.
- redirect_valid with redirect_pc=8'h40 while stall=1 -> next cycle if_valid=0, if_inst=0000, imem_add=40; following cycle if_inst=RAM[40].
- PC at 8'hFF with RAM[FF]=16'h5555 -> if_pc=FF, if_pc_plus1=00, next imem_add=00.
- RAM[5]=FFFF -> IF/ID holds FFFF valid, halted=1, pc stays 5; next unstalled cycle if_valid=0; redirect to 8'h10 clears halted and fetches RAM[10].
- rst asserted mid-stream at pc=7 between clock edges -> outputs return to reset values immediately; after release fetch restarts at RESET_PC.
